// File: rtl/antares_pipe_pkg.sv
// ============================================================================
// Module   : antares_pipe_pkg
// Purpose  : Shared types and constants for the Antares-R2 pipeline control
//            sequencer (state encoding, zero register, default watchdog limit).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package antares_pipe_pkg;

    // Sequencer states; encoding is fixed so it can be mirrored as constants.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MDWAIT  = 2'd2,
        FAULT   = 2'd3
    } pipeState_e;

    // Register $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default number of consecutive memory-wait cycles tolerated.
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    // True when the ID instruction reads the register a load in EX produces.
    function automatic logic loadUseHit(
        input logic       memRead,
        input logic [4:0] rtEx,
        input logic [4:0] rsId,
        input logic [4:0] rtId,
        input logic       useRs,
        input logic       useRt
    );
        return memRead && (rtEx != REG_ZERO) &&
               ((useRs && (rsId == rtEx)) || (useRt && (rtId == rtEx)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module   : pipeline_ctrl_if
// Purpose  : Hazard inputs and per-stage control outputs of the pipeline
//            sequencer. The pipeline side is the master, the sequencer the
//            slave.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if;
    // Hazard sources
    logic [4:0]  rsID;
    logic [4:0]  rtID;
    logic        useRsID;
    logic        useRtID;
    logic [4:0]  rtEX;
    logic        memReadEx;
    logic        branchTakenEx;
    logic        mdStartID;
    logic        mdReadID;
    logic        mdBusy;
    logic        memWaitMem;

    // Stage controls and status
    logic        pcWrite;
    logic        ifIdWrite;
    logic        idExWrite;
    logic        exMemWrite;
    logic        memWbWrite;
    logic        flushIfId;
    logic        flushIdEx;
    logic        memFault;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    modport master (
        output rsID, rtID, useRsID, useRtID, rtEX, memReadEx, branchTakenEx,
               mdStartID, mdReadID, mdBusy, memWaitMem,
        input  pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite,
               flushIfId, flushIdEx, memFault, stallCnt, flushCnt
    );

    modport slave (
        input  rsID, rtID, useRsID, useRtID, rtEX, memReadEx, branchTakenEx,
               mdStartID, mdReadID, mdBusy, memWaitMem,
        output pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite,
               flushIfId, flushIdEx, memFault, stallCnt, flushCnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_mem_wait_watchdog.sv
// ============================================================================
// Module   : mem_wait_watchdog
// Purpose  : Counts consecutive data-memory wait cycles and pulses o_timeout
//            on the wait cycle that reaches MEM_TIMEOUT.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wait_watchdog
    import antares_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_memWait,
    output logic      o_timeout
);
    localparam int                 c_CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(MEM_TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_waitCnt;

    // Count consecutive wait cycles; any ready cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !i_memWait) begin
            r_waitCnt <= '0;
        end else begin
            r_waitCnt <= r_waitCnt + c_CNT_W'(1);
        end
    end

    // Fires on the wait cycle that completes MEM_TIMEOUT consecutive waits.
    assign o_timeout = i_memWait && (r_waitCnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall/flush sequencer for the five-stage pipeline. Merges
//            load-use, branch redirect, mult/div busy and memory wait into
//            per-stage enables and flushes; latches a sticky memory fault.
//            Optional feature macro: PIPE_PERF_EN (stall/flush counters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
    import antares_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      rst,
    pipeline_ctrl_if.slave pipe
);
    localparam logic [1:0] c_RUN     = RUN;
    localparam logic [1:0] c_LDSTALL = LDSTALL;
    localparam logic [1:0] c_MDWAIT  = MDWAIT;
    localparam logic [1:0] c_FAULT   = FAULT;

    logic [1:0] r_state;
    logic [1:0] w_nextState;
    logic       w_timeout;
    logic       w_loadUse;
    logic       w_mdHazard;
    logic       w_pcWrite;
    logic       w_ifIdWrite;
    logic       w_idExWrite;
    logic       w_exMemWrite;
    logic       w_memWbWrite;
    logic       w_flushIfId;
    logic       w_flushIdEx;
    logic       w_memFault;

    // Wait counting stops in FAULT so the counter is idle until reset.
    mem_wait_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_memWait (pipe.memWaitMem && (r_state != c_FAULT)),
        .o_timeout (w_timeout)
    );

    assign w_loadUse  = loadUseHit(pipe.memReadEx, pipe.rtEX, pipe.rsID,
                                   pipe.rtID, pipe.useRsID, pipe.useRtID);
    assign w_mdHazard = (pipe.mdStartID || pipe.mdReadID) && pipe.mdBusy;

    // Prioritised Mealy decode of enables, flushes and next state.
    always_comb begin
        w_pcWrite    = 1'b1;
        w_ifIdWrite  = 1'b1;
        w_idExWrite  = 1'b1;
        w_exMemWrite = 1'b1;
        w_memWbWrite = 1'b1;
        w_flushIfId  = 1'b0;
        w_flushIdEx  = 1'b0;
        w_memFault   = 1'b0;
        w_nextState  = r_state;

        if (rst) begin
            {w_pcWrite, w_ifIdWrite, w_idExWrite, w_exMemWrite, w_memWbWrite} = 5'b00000;
            w_flushIfId = 1'b1;
            w_flushIdEx = 1'b1;
            w_nextState = c_RUN;
        end else if (r_state == c_FAULT) begin
            {w_pcWrite, w_ifIdWrite, w_idExWrite, w_exMemWrite, w_memWbWrite} = 5'b00000;
            w_memFault = 1'b1;
        end else if (pipe.memWaitMem) begin
            // Freeze the whole pipe; state is held so the pending stall resumes.
            {w_pcWrite, w_ifIdWrite, w_idExWrite, w_exMemWrite, w_memWbWrite} = 5'b00000;
            if (w_timeout) begin
                w_nextState = c_FAULT;
            end
        end else if (pipe.branchTakenEx) begin
            // Redirect wins over any stall: younger instructions are discarded.
            w_flushIfId = 1'b1;
            w_flushIdEx = 1'b1;
            w_nextState = c_RUN;
        end else begin
            case (r_state)
                c_RUN: begin
                    if (w_loadUse) begin
                        w_pcWrite   = 1'b0;
                        w_ifIdWrite = 1'b0;
                        w_flushIdEx = 1'b1;
                        w_nextState = c_LDSTALL;
                    end else if (w_mdHazard) begin
                        w_pcWrite   = 1'b0;
                        w_ifIdWrite = 1'b0;
                        w_flushIdEx = 1'b1;
                        w_nextState = c_MDWAIT;
                    end
                end
                c_LDSTALL: begin
                    // Bubble already inserted; the load result is now forwardable.
                    w_nextState = c_RUN;
                end
                c_MDWAIT: begin
                    if (pipe.mdBusy) begin
                        w_pcWrite   = 1'b0;
                        w_ifIdWrite = 1'b0;
                        w_flushIdEx = 1'b1;
                    end else begin
                        w_nextState = c_RUN;
                    end
                end
                default: begin
                    w_nextState = c_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign pipe.pcWrite    = w_pcWrite;
    assign pipe.ifIdWrite  = w_ifIdWrite;
    assign pipe.idExWrite  = w_idExWrite;
    assign pipe.exMemWrite = w_exMemWrite;
    assign pipe.memWbWrite = w_memWbWrite;
    assign pipe.flushIfId  = w_flushIfId;
    assign pipe.flushIdEx  = w_flushIdEx;
    assign pipe.memFault   = w_memFault;

`ifdef PIPE_PERF_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_flushCnt;

    // Count stalled cycles and branch redirects; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if ((r_state != c_FAULT) && !w_pcWrite) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (w_flushIfId) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
        end
    end

    assign pipe.stallCnt = r_stallCnt;
    assign pipe.flushCnt = r_flushCnt;
`else
    assign pipe.stallCnt = '0;
    assign pipe.flushCnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Scoreboard bench for pipeline_ctrl with MEM_TIMEOUT=4. Directed
//            vectors push expected outputs; a monitor compares each cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipeline_ctrl_if pif ();

    pipeline_ctrl #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (pif)
    );

    typedef struct {
        string       name;
        logic [4:0]  en;     // {pc, ifId, idEx, exMem, memWb}
        logic        fIfId;
        logic        fIdEx;
        logic        fault;
        logic        chkCnt;
        logic [31:0] sCnt;
        logic [31:0] fCnt;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cycles = 0;
    logic        done  = 1'b0;
    logic        cntKnown = 1'b0;
    logic [31:0] expStall = '0;
    logic [31:0] expFlush = '0;

    task automatic clr();
        pif.rsID          = 5'd0;
        pif.rtID          = 5'd0;
        pif.useRsID       = 1'b0;
        pif.useRtID       = 1'b0;
        pif.rtEX          = 5'd0;
        pif.memReadEx     = 1'b0;
        pif.branchTakenEx = 1'b0;
        pif.mdStartID     = 1'b0;
        pif.mdReadID      = 1'b0;
        pif.mdBusy        = 1'b0;
        pif.memWaitMem    = 1'b0;
    endtask

    // Push the expected response for the inputs now applied, then advance.
    task automatic cyc(input string nm, input logic [4:0] en,
                       input logic fi, input logic fe, input logic flt);
        exp_t e;
        e.name   = nm;
        e.en     = en;
        e.fIfId  = fi;
        e.fIdEx  = fe;
        e.fault  = flt;
        e.chkCnt = cntKnown;
`ifdef PIPE_PERF_EN
        e.sCnt   = expStall;
        e.fCnt   = expFlush;
`else
        e.sCnt   = 32'd0;
        e.fCnt   = 32'd0;
`endif
        q.push_back(e);
        if (rst) begin
            expStall = '0;
            expFlush = '0;
            cntKnown = 1'b1;
        end else begin
            if (!flt && !en[4]) expStall = expStall + 32'd1;
            if (fi) expFlush = expFlush + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst0", 5'b00000, 1'b1, 1'b1, 1'b0);
        cyc("rst1", 5'b00000, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        cyc("idle0", 5'b11111, 1'b0, 1'b0, 1'b0);
        cyc("idle1", 5'b11111, 1'b0, 1'b0, 1'b0);

        // Load-use on rs: one stall then the bubble cycle advances.
        pif.memReadEx = 1'b1; pif.rtEX = 5'd5; pif.rsID = 5'd5; pif.useRsID = 1'b1;
        cyc("lu_stall",  5'b00111, 1'b0, 1'b1, 1'b0);
        cyc("lu_bubble", 5'b11111, 1'b0, 1'b0, 1'b0);
        clr();
        cyc("lu_idle",   5'b11111, 1'b0, 1'b0, 1'b0);

        // Load into $zero is never a hazard.
        pif.memReadEx = 1'b1; pif.rtEX = 5'd0; pif.rsID = 5'd0; pif.useRsID = 1'b1;
        cyc("lu_zero",   5'b11111, 1'b0, 1'b0, 1'b0);
        clr();

        // Load-use on rt.
        pif.memReadEx = 1'b1; pif.rtEX = 5'd7; pif.rtID = 5'd7; pif.useRtID = 1'b1;
        cyc("lu_rt",     5'b00111, 1'b0, 1'b1, 1'b0);
        clr();
        cyc("lu_rt_end", 5'b11111, 1'b0, 1'b0, 1'b0);

        // Matching registers that are not actually read.
        pif.memReadEx = 1'b1; pif.rtEX = 5'd9; pif.rsID = 5'd9; pif.rtID = 5'd9;
        cyc("lu_nouse",  5'b11111, 1'b0, 1'b0, 1'b0);
        clr();

        // mfhi/mflo while mult/div busy for 4 cycles.
        pif.mdReadID = 1'b1; pif.mdBusy = 1'b1;
        for (int i = 0; i < 4; i++) cyc("md_wait", 5'b00111, 1'b0, 1'b1, 1'b0);
        pif.mdBusy = 1'b0;
        cyc("md_done",   5'b11111, 1'b0, 1'b0, 1'b0);
        clr();

        // Branch during MDWAIT returns to RUN (no md instruction -> no stall).
        pif.mdReadID = 1'b1; pif.mdBusy = 1'b1;
        cyc("mdb_wait",  5'b00111, 1'b0, 1'b1, 1'b0);
        pif.branchTakenEx = 1'b1;
        cyc("mdb_flush", 5'b11111, 1'b1, 1'b1, 1'b0);
        pif.branchTakenEx = 1'b0; pif.mdReadID = 1'b0;
        cyc("mdb_run",   5'b11111, 1'b0, 1'b0, 1'b0);
        clr();

        // Branch with load-use: flush only, stays in RUN (md hazard then stalls).
        pif.memReadEx = 1'b1; pif.rtEX = 5'd3; pif.rsID = 5'd3; pif.useRsID = 1'b1;
        pif.branchTakenEx = 1'b1;
        cyc("lub_flush", 5'b11111, 1'b1, 1'b1, 1'b0);
        clr();
        pif.mdStartID = 1'b1; pif.mdBusy = 1'b1;
        cyc("lub_run",   5'b00111, 1'b0, 1'b1, 1'b0);
        clr();
        cyc("lub_mdend", 5'b11111, 1'b0, 1'b0, 1'b0);

        // Memory wait 3 cycles (one short): no fault; wait beats branch.
        pif.memWaitMem = 1'b1; pif.branchTakenEx = 1'b1;
        cyc("mw_prio",   5'b00000, 1'b0, 1'b0, 1'b0);
        pif.branchTakenEx = 1'b0;
        cyc("mw_2",      5'b00000, 1'b0, 1'b0, 1'b0);
        cyc("mw_3",      5'b00000, 1'b0, 1'b0, 1'b0);
        pif.memWaitMem = 1'b0;
        cyc("mw_short",  5'b11111, 1'b0, 1'b0, 1'b0);

        // Memory wait 4 cycles: fault on cycle 5, sticky until reset.
        pif.memWaitMem = 1'b1;
        for (int i = 0; i < 4; i++) cyc("mwf_wait", 5'b00000, 1'b0, 1'b0, 1'b0);
        pif.memWaitMem = 1'b0;
        cyc("flt_rise",  5'b00000, 1'b0, 1'b0, 1'b1);
        pif.branchTakenEx = 1'b1;
        cyc("flt_hold",  5'b00000, 1'b0, 1'b0, 1'b1);
        clr();
        cyc("flt_hold2", 5'b00000, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc("flt_rst",   5'b00000, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        cyc("post_rst",  5'b11111, 1'b0, 1'b0, 1'b0);

        // After reset a load-use works normally again.
        pif.memReadEx = 1'b1; pif.rtEX = 5'd12; pif.rtID = 5'd12; pif.useRtID = 1'b1;
        cyc("rst_lu",    5'b00111, 1'b0, 1'b1, 1'b0);
        clr();
        cyc("final",     5'b11111, 1'b0, 1'b0, 1'b0);
        done = 1'b1;
    end

    // Monitor: compare DUT outputs against the scoreboard each cycle.
    initial begin : monitor
        exp_t       e;
        logic [4:0] en;
        forever begin
            @(negedge clk);
            cycles++;
            if (q.size() != 0) begin
                e  = q.pop_front();
                en = {pif.pcWrite, pif.ifIdWrite, pif.idExWrite, pif.exMemWrite, pif.memWbWrite};
                total++;
                if (en !== e.en || pif.flushIfId !== e.fIfId ||
                    pif.flushIdEx !== e.fIdEx || pif.memFault !== e.fault) begin
                    bad++;
                    $display("FAIL %s: en/fIfId/fIdEx/fault got %b/%b/%b/%b need %b/%b/%b/%b",
                             e.name, en, pif.flushIfId, pif.flushIdEx, pif.memFault,
                             e.en, e.fIfId, e.fIdEx, e.fault);
                end
                if (e.chkCnt) begin
                    total++;
                    if (pif.stallCnt !== e.sCnt || pif.flushCnt !== e.fCnt) begin
                        bad++;
                        $display("FAIL %s_cnt: stall/flush got %0d/%0d need %0d/%0d",
                                 e.name, pif.stallCnt, pif.flushCnt, e.sCnt, e.fCnt);
                    end
                end
            end
            if (done && q.size() == 0) break;
            if (cycles > 2000) begin
                total++;
                bad++;
                $display("FAIL watchdog: pending=%0d need 0", q.size());
                break;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
